// File: rtl/ex_stage_if.sv
// Bundle between ID_EX_Reg, the execute stage and the EX/MEM consumers.
// The ex_stage side is the slave; the pipeline/hazard side is the master.
interface ex_stage_if;
    logic        RegWriteE, MemtoRegE, MemWriteE, ALUSrcE, RegDstE, LinkE;
    logic [2:0]  ALUControlE;
    logic [2:0]  MdOpE;
    logic [31:0] ReadData1E, ReadData2E, SignImmE, PCPlus4E;
    logic [4:0]  RtE, RdE, ShamtE;
    logic [1:0]  ForwardAE, ForwardBE;
    logic [31:0] ResultW;
    logic        StallE;
    logic        MdBusy;
    logic        RegWriteM, MemtoRegM, MemWriteM;
    logic [31:0] ALUOutM, WriteDataM;
    logic [4:0]  WriteRegM;

    modport master (
        output RegWriteE, MemtoRegE, MemWriteE, ALUSrcE, RegDstE, LinkE,
        output ALUControlE, MdOpE, ReadData1E, ReadData2E, SignImmE, PCPlus4E,
        output RtE, RdE, ShamtE, ForwardAE, ForwardBE, ResultW,
        input  StallE, MdBusy, RegWriteM, MemtoRegM, MemWriteM,
        input  ALUOutM, WriteDataM, WriteRegM
    );

    modport slave (
        input  RegWriteE, MemtoRegE, MemWriteE, ALUSrcE, RegDstE, LinkE,
        input  ALUControlE, MdOpE, ReadData1E, ReadData2E, SignImmE, PCPlus4E,
        input  RtE, RdE, ShamtE, ForwardAE, ForwardBE, ResultW,
        output StallE, MdBusy, RegWriteM, MemtoRegM, MemWriteM,
        output ALUOutM, WriteDataM, WriteRegM
    );
endinterface

// File: rtl/ex_stage.sv
// MIPS execute stage: forwarding, ALU, EX/MEM register and an iterative
// 32-cycle unsigned MULTU/DIVU unit with HI/LO.
module ex_stage (
    input logic       clk,
    input logic       rst,
    ex_stage_if.slave bus
);
    localparam int MD_CYCLES = 32;

    typedef enum logic [1:0] {MD_IDLE, MD_MUL, MD_DIV} md_state_t;

    md_state_t   mdState;
    logic [4:0]  mdCount;
    logic [31:0] mdOperand;
    logic [63:0] mdAcc;
    logic [63:0] mdAccNext;
    logic [32:0] mulSum, divShift, divTrial;
    logic [31:0] hi, lo;

    logic [31:0] srcA, fwdB, srcB, aluResult, exResult;
    logic [4:0]  writeReg;
    logic        mdStart;

    always_comb begin
        case (bus.ForwardAE)
            2'b01:   srcA = bus.ResultW;
            2'b10:   srcA = bus.ALUOutM;
            default: srcA = bus.ReadData1E;
        endcase
        case (bus.ForwardBE)
            2'b01:   fwdB = bus.ResultW;
            2'b10:   fwdB = bus.ALUOutM;
            default: fwdB = bus.ReadData2E;
        endcase
        srcB = bus.ALUSrcE ? bus.SignImmE : fwdB;
    end

    always_comb begin
        case (bus.ALUControlE)
            3'b000:  aluResult = srcA & srcB;
            3'b001:  aluResult = srcA | srcB;
            3'b010:  aluResult = srcA + srcB;
            3'b011:  aluResult = srcB << bus.ShamtE;
            3'b100:  aluResult = srcB >> bus.ShamtE;
            3'b101:  aluResult = $signed(srcB) >>> bus.ShamtE;
            3'b110:  aluResult = srcA - srcB;
            default: aluResult = {31'd0, $signed(srcA) < $signed(srcB)};
        endcase
    end

    always_comb begin
        if (bus.LinkE)
            exResult = bus.PCPlus4E;
        else if (bus.MdOpE == 3'b011)
            exResult = lo;
        else if (bus.MdOpE == 3'b100)
            exResult = hi;
        else
            exResult = aluResult;
        writeReg = bus.LinkE ? 5'd31 : (bus.RegDstE ? bus.RdE : bus.RtE);
    end

    assign bus.MdBusy = (mdState != MD_IDLE);
    assign bus.StallE = bus.MdBusy & (bus.MdOpE != 3'b000);
    assign mdStart    = !bus.StallE && (bus.MdOpE == 3'b001 || bus.MdOpE == 3'b010);

    // One iteration step. Multiply keeps {partial product, multiplier} in mdAcc;
    // divide keeps {remainder, dividend/quotient}, so both finish as {HI, LO}.
    always_comb begin
        mulSum   = {1'b0, mdAcc[63:32]} + {1'b0, (mdAcc[0] ? mdOperand : 32'd0)};
        divShift = mdAcc[63:31];
        divTrial = divShift - {1'b0, mdOperand};
        if (mdState == MD_DIV)
            mdAccNext = divTrial[32] ? {divShift[31:0], mdAcc[30:0], 1'b0}
                                     : {divTrial[31:0], mdAcc[30:0], 1'b1};
        else
            mdAccNext = {mulSum, mdAcc[31:1]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mdState   <= MD_IDLE;
            mdCount   <= 5'd0;
            mdAcc     <= 64'd0;
            mdOperand <= 32'd0;
            hi        <= 32'd0;
            lo        <= 32'd0;
        end else begin
            case (mdState)
                MD_IDLE: begin
                    if (mdStart) begin
                        mdCount <= 5'd0;
                        if (bus.MdOpE == 3'b001) begin
                            mdState   <= MD_MUL;
                            mdAcc     <= {32'd0, fwdB};
                            mdOperand <= srcA;
                        end else begin
                            mdState   <= MD_DIV;
                            mdAcc     <= {32'd0, srcA};
                            mdOperand <= fwdB;
                        end
                    end
                end
                default: begin
                    mdAcc   <= mdAccNext;
                    mdCount <= mdCount + 5'd1;
                    if (mdCount == 5'(MD_CYCLES - 1)) begin
                        hi      <= mdAccNext[63:32];
                        lo      <= mdAccNext[31:0];
                        mdState <= MD_IDLE;
                        mdCount <= 5'd0;
                    end
                end
            endcase
        end
    end

    // A stalled cycle sends a bubble downstream while upstream holds.
    always_ff @(posedge clk) begin
        if (rst || bus.StallE) begin
            bus.RegWriteM  <= 1'b0;
            bus.MemtoRegM  <= 1'b0;
            bus.MemWriteM  <= 1'b0;
            bus.ALUOutM    <= 32'd0;
            bus.WriteDataM <= 32'd0;
            bus.WriteRegM  <= 5'd0;
        end else begin
            bus.RegWriteM  <= bus.RegWriteE;
            bus.MemtoRegM  <= bus.MemtoRegE;
            bus.MemWriteM  <= bus.MemWriteE;
            bus.ALUOutM    <= exResult;
            bus.WriteDataM <= fwdB;
            bus.WriteRegM  <= writeReg;
        end
    end
endmodule

// File: tb/tb_ex_stage.sv
// Scoreboard bench for ex_stage: a driver pushes model expectations per cycle,
// a monitor pops and compares stall/busy before the edge and EX/MEM after it.
module tb_ex_stage;
    logic clk = 1'b0;
    logic rst;

    ex_stage_if bus ();
    ex_stage dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    typedef struct packed {
        logic        rst;
        logic        regWrite, memtoReg, memWrite, aluSrc, regDst, link;
        logic [2:0]  aluCtl, mdOp;
        logic [31:0] rd1, rd2, imm, pc4;
        logic [4:0]  rt, rd, shamt;
        logic [1:0]  fa, fb;
        logic [31:0] resultW;
    } StimItem;

    typedef struct packed {
        logic        regWrite, memtoReg, memWrite;
        logic [31:0] aluOut, writeData;
        logic [4:0]  writeReg;
    } MemItem;

    typedef struct packed {
        logic stall, busy;
    } StallItem;

    MemItem   mQ[$];
    StallItem sQ[$];
    int       total = 0;
    int       bad = 0;
    logic     driverDone = 1'b0;

    // Reference model state: HI/LO, cycles left on the unit, and its pending answer.
    logic [31:0] modelHi = 32'd0, modelLo = 32'd0, modelAluOutM = 32'd0;
    logic [63:0] pendingHiLo = 64'd0;
    int          mdLeft = 0;
    logic        lastStall = 1'b0;

    function automatic logic [31:0] pick(input logic [1:0] sel, input logic [31:0] reg_,
                                         input logic [31:0] resW, input logic [31:0] aluM);
        if (sel == 2'b01) return resW;
        if (sel == 2'b10) return aluM;
        return reg_;
    endfunction

    function automatic logic [31:0] refAlu(input logic [2:0] ctl, input logic [31:0] a,
                                           input logic [31:0] b, input logic [4:0] sh);
        logic [31:0] ones;
        ones = 32'hFFFF_FFFF;
        case (ctl)
            3'b000: return a & b;
            3'b001: return a | b;
            3'b010: return a + b;
            3'b110: return a + ~b + 32'd1;
            3'b011: return b << sh;
            3'b100: return b >> sh;
            3'b101: return (b >> sh) | (b[31] ? ~(ones >> sh) : 32'd0);
            default: begin
                if (a[31] != b[31]) return {31'd0, a[31]};
                return {31'd0, a < b};
            end
        endcase
    endfunction

    function automatic StimItem aluInstr(input logic [2:0] ctl, input logic [31:0] a,
                                         input logic [31:0] b);
        StimItem s;
        s = '0;
        s.regWrite = 1'b1;
        s.regDst   = 1'b1;
        s.aluCtl   = ctl;
        s.rd1      = a;
        s.rd2      = b;
        s.rt       = 5'd9;
        s.rd       = 5'd8;
        return s;
    endfunction

    function automatic StimItem mdInstr(input logic [2:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
        StimItem s;
        s = '0;
        s.mdOp = op;
        s.rd1  = a;
        s.rd2  = b;
        if (op == 3'b011 || op == 3'b100) begin
            s.regWrite = 1'b1;
            s.regDst   = 1'b1;
            s.rd       = 5'd10;
        end
        return s;
    endfunction

    // Drive one cycle's inputs, push what the model expects, advance the model.
    task automatic applyStimulus(input StimItem s);
        logic [31:0] a, fb, b, res;
        logic        stall;
        MemItem      e;
        StallItem    si;
        @(negedge clk);
        rst             = s.rst;
        bus.RegWriteE   = s.regWrite;
        bus.MemtoRegE   = s.memtoReg;
        bus.MemWriteE   = s.memWrite;
        bus.ALUSrcE     = s.aluSrc;
        bus.RegDstE     = s.regDst;
        bus.LinkE       = s.link;
        bus.ALUControlE = s.aluCtl;
        bus.MdOpE       = s.mdOp;
        bus.ReadData1E  = s.rd1;
        bus.ReadData2E  = s.rd2;
        bus.SignImmE    = s.imm;
        bus.PCPlus4E    = s.pc4;
        bus.RtE         = s.rt;
        bus.RdE         = s.rd;
        bus.ShamtE      = s.shamt;
        bus.ForwardAE   = s.fa;
        bus.ForwardBE   = s.fb;
        bus.ResultW     = s.resultW;

        a     = pick(s.fa, s.rd1, s.resultW, modelAluOutM);
        fb    = pick(s.fb, s.rd2, s.resultW, modelAluOutM);
        b     = s.aluSrc ? s.imm : fb;
        stall = (mdLeft > 0) && (s.mdOp != 3'b000);
        si.stall = stall;
        si.busy  = (mdLeft > 0);
        sQ.push_back(si);

        if (s.link)                res = s.pc4;
        else if (s.mdOp == 3'b011) res = modelLo;
        else if (s.mdOp == 3'b100) res = modelHi;
        else                       res = refAlu(s.aluCtl, a, b, s.shamt);

        if (s.rst || stall) begin
            e = '0;
        end else begin
            e.regWrite  = s.regWrite;
            e.memtoReg  = s.memtoReg;
            e.memWrite  = s.memWrite;
            e.aluOut    = res;
            e.writeData = fb;
            e.writeReg  = s.link ? 5'd31 : (s.regDst ? s.rd : s.rt);
        end
        mQ.push_back(e);
        lastStall = stall;

        if (s.rst) begin
            mdLeft  = 0;
            modelHi = 32'd0;
            modelLo = 32'd0;
        end else if (mdLeft > 0) begin
            mdLeft--;
            if (mdLeft == 0) {modelHi, modelLo} = pendingHiLo;
        end else if (!stall && (s.mdOp == 3'b001 || s.mdOp == 3'b010)) begin
            if (s.mdOp == 3'b001)  pendingHiLo = {32'd0, a} * {32'd0, fb};
            else if (fb == 32'd0)  pendingHiLo = {a, 32'hFFFF_FFFF};
            else                   pendingHiLo = {a % fb, a / fb};
            mdLeft = 32;
        end
        modelAluOutM = e.aluOut;
        @(posedge clk);
    endtask

    // Re-present an instruction the way a frozen upstream would, until it passes.
    task automatic issueHeld(input StimItem s);
        int n;
        n = 0;
        do begin
            applyStimulus(s);
            n++;
        end while (lastStall && n < 40);
    endtask

    task automatic checkOutput();
        MemItem   e, got;
        StallItem se, sg;
        while (!(driverDone && mQ.size() == 0 && sQ.size() == 0)) begin
            @(negedge clk);
            #2;
            if (sQ.size() > 0) begin
                se = sQ.pop_front();
                sg.stall = bus.StallE;
                sg.busy  = bus.MdBusy;
                total++;
                if (sg !== se) begin
                    bad++;
                    $display("[TB] FAIL stall/busy t=%0t: got stall=%0b busy=%0b, need stall=%0b busy=%0b",
                             $time, sg.stall, sg.busy, se.stall, se.busy);
                end
            end
            @(posedge clk);
            #1;
            if (mQ.size() > 0) begin
                e = mQ.pop_front();
                got.regWrite  = bus.RegWriteM;
                got.memtoReg  = bus.MemtoRegM;
                got.memWrite  = bus.MemWriteM;
                got.aluOut    = bus.ALUOutM;
                got.writeData = bus.WriteDataM;
                got.writeReg  = bus.WriteRegM;
                total++;
                if (got !== e) begin
                    bad++;
                    $display("[TB] FAIL exmem t=%0t: got rw=%0b mr=%0b mw=%0b alu=%h wd=%h wr=%0d, need rw=%0b mr=%0b mw=%0b alu=%h wd=%h wr=%0d",
                             $time, got.regWrite, got.memtoReg, got.memWrite, got.aluOut,
                             got.writeData, got.writeReg, e.regWrite, e.memtoReg, e.memWrite,
                             e.aluOut, e.writeData, e.writeReg);
                end
            end
        end
    endtask

    task automatic runDriver();
        StimItem s;
        s = '0;
        s.rst = 1'b1;
        applyStimulus(s);
        applyStimulus(s);

        // ALU and forwarding directed cases
        applyStimulus(aluInstr(3'b010, 32'd5, 32'd0));
        s = aluInstr(3'b010, 32'd99, 32'd7);
        s.fa = 2'b10;
        applyStimulus(s);
        applyStimulus(aluInstr(3'b110, 32'd3, 32'd5));
        applyStimulus(aluInstr(3'b111, 32'hFFFF_FFFF, 32'd1));
        s = aluInstr(3'b101, 32'd0, 32'h8000_0000);
        s.shamt = 5'd4;
        applyStimulus(s);
        s = aluInstr(3'b001, 32'd0, 32'd0);
        s.fa = 2'b01;
        s.fb = 2'b11;
        s.rd2 = 32'h00F0_0000;
        s.resultW = 32'h0000_000F;
        s.aluSrc = 1'b1;
        s.imm = 32'h1234_0000;
        s.memWrite = 1'b1;
        applyStimulus(s);

        // MULTU then an immediately dependent MFHI, then MFLO
        applyStimulus(mdInstr(3'b001, 32'hFFFF_FFFF, 32'd2));
        issueHeld(mdInstr(3'b100, 32'd0, 32'd0));
        issueHeld(mdInstr(3'b011, 32'd0, 32'd0));

        // DIVU, including divide by zero
        applyStimulus(mdInstr(3'b010, 32'd100, 32'd7));
        issueHeld(mdInstr(3'b011, 32'd0, 32'd0));
        issueHeld(mdInstr(3'b100, 32'd0, 32'd0));
        applyStimulus(mdInstr(3'b010, 32'd9, 32'd0));
        issueHeld(mdInstr(3'b011, 32'd0, 32'd0));
        issueHeld(mdInstr(3'b100, 32'd0, 32'd0));

        // Independent ADDs keep flowing while the unit is busy
        applyStimulus(mdInstr(3'b001, $urandom, $urandom));
        for (int i = 0; i < 8; i++) begin
            s = aluInstr(3'b010, $urandom, $urandom);
            s.fb = 2'(i % 3);
            s.resultW = $urandom;
            applyStimulus(s);
        end
        issueHeld(mdInstr(3'b011, 32'd0, 32'd0));
        issueHeld(mdInstr(3'b100, 32'd0, 32'd0));

        // JAL
        s = '0;
        s.link = 1'b1;
        s.regWrite = 1'b1;
        s.pc4 = 32'h0040_0010;
        s.rt = 5'd4;
        applyStimulus(s);

        // Reset in the middle of a MULTU discards it
        applyStimulus(mdInstr(3'b001, 32'd1234, 32'd5678));
        for (int i = 0; i < 9; i++) applyStimulus(aluInstr(3'b000, 32'd0, 32'd0));
        s = '0;
        s.rst = 1'b1;
        s.regWrite = 1'b1;
        s.mdOp = 3'b011;
        applyStimulus(s);
        applyStimulus(s);
        issueHeld(mdInstr(3'b011, 32'd0, 32'd0));
        issueHeld(mdInstr(3'b100, 32'd0, 32'd0));

        // Random traffic
        for (int i = 0; i < 500; i++) begin
            int r;
            s = '0;
            s.rst      = ($urandom_range(0, 149) == 0);
            s.regWrite = 1'($urandom_range(0, 1));
            s.memtoReg = 1'($urandom_range(0, 1));
            s.memWrite = 1'($urandom_range(0, 1));
            s.aluSrc   = 1'($urandom_range(0, 1));
            s.regDst   = 1'($urandom_range(0, 1));
            s.link     = ($urandom_range(0, 15) == 0);
            s.aluCtl   = 3'($urandom_range(0, 7));
            r = $urandom_range(0, 11);
            s.mdOp     = (r < 7) ? 3'd0 : 3'(r - 6 > 4 ? 1 : r - 6);
            s.rd1      = $urandom_range(0, 1) ? $urandom : 32'($urandom_range(0, 300));
            s.rd2      = $urandom_range(0, 1) ? $urandom : 32'($urandom_range(0, 20));
            s.imm      = $urandom;
            s.pc4      = $urandom;
            s.rt       = 5'($urandom_range(0, 31));
            s.rd       = 5'($urandom_range(0, 31));
            s.shamt    = 5'($urandom_range(0, 31));
            s.fa       = 2'($urandom_range(0, 3));
            s.fb       = 2'($urandom_range(0, 3));
            s.resultW  = $urandom;
            applyStimulus(s);
        end
        driverDone = 1'b1;
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        rst = 1'b1;
        bus.RegWriteE = 1'b0; bus.MemtoRegE = 1'b0; bus.MemWriteE = 1'b0;
        bus.ALUSrcE = 1'b0; bus.RegDstE = 1'b0; bus.LinkE = 1'b0;
        bus.ALUControlE = 3'd0; bus.MdOpE = 3'd0;
        bus.ReadData1E = 32'd0; bus.ReadData2E = 32'd0;
        bus.SignImmE = 32'd0; bus.PCPlus4E = 32'd0;
        bus.RtE = 5'd0; bus.RdE = 5'd0; bus.ShamtE = 5'd0;
        bus.ForwardAE = 2'd0; bus.ForwardBE = 2'd0; bus.ResultW = 32'd0;
        fork
            runDriver();
            checkOutput();
        join
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
